// File: rtl/ssd_scan.sv
// ssd_scan: time-multiplexed scan driver for a common-anode seven-segment
// display fed by a chain of BCD counters.
//
// Once per frame, on the first cycle of slot 0, it takes a snapshot of all
// digits and their decimal points. Each digit slot lasts REFRESH_DIV cycles.
// The first BLANK_CYCLES cycles of a slot keep every anode off so the
// previous digit does not ghost onto the next one. All outputs are
// registered.
//
// Ports:
//   ssd_clk     system clock
//   ssd_rst_n   asynchronous active-low reset
//   ssd_en      scan enable; while low, position and snapshot freeze and the
//               display goes dark
//   ssd_lzb     leading-zero blanking enable (sampled live)
//   ssd_digits  BCD digits; [3:0] is digit 0 (rightmost)
//   ssd_dp      per-digit decimal-point request, 1 = lit
//   ssd_an      anode selects, active-low, bit i = digit i
//   ssd_seg     segments a..g on [0]..[6], active-low
//   ssd_dp_n    decimal point, active-low
//   ssd_frame   one-cycle pulse on the output cycle after a frame capture
module ssd_scan #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic                    ssd_clk,
  input  logic                    ssd_rst_n,
  input  logic                    ssd_en,
  input  logic                    ssd_lzb,
  input  logic [4*NUM_DIGITS-1:0] ssd_digits,
  input  logic [NUM_DIGITS-1:0]   ssd_dp,
  output logic [NUM_DIGITS-1:0]   ssd_an,
  output logic [6:0]              ssd_seg,
  output logic                    ssd_dp_n,
  output logic                    ssd_frame
);

  localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned SW = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;

  logic [CW-1:0]           cnt_q, cnt_d;
  logic [SW-1:0]           slot_q, slot_d;
  logic [4*NUM_DIGITS-1:0] sh_dig_q, sh_dig_d;
  logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_n_q, dp_n_d;
  logic                    frame_q, frame_d;

  // Active-low g..a pattern; anything that is not a BCD digit shows a dash.
  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b0111111;
    endcase
  endfunction

  logic [3:0]            cur_dig;
  logic                  cur_dp;
  logic                  cur_lz;
  logic [NUM_DIGITS-1:0] zero_from;

  // zero_from[i] is set when shadow digits i..NUM_DIGITS-1 are all zero.
  // The scan walks from the most significant digit downwards.
  always_comb begin
    logic all_zero;
    int unsigned idx;
    all_zero  = 1'b1;
    zero_from = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      idx = NUM_DIGITS - 1 - i;
      all_zero = all_zero & (sh_dig_q[4*idx +: 4] == 4'd0);
      zero_from[idx] = all_zero;
    end
  end

  always_comb begin
    cur_dig = '0;
    cur_dp  = 1'b0;
    cur_lz  = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (slot_q == SW'(i)) begin
        cur_dig = sh_dig_q[4*i +: 4];
        cur_dp  = sh_dp_q[i];
        cur_lz  = (i != 0) && zero_from[i];
      end
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    slot_d   = slot_q;
    sh_dig_d = sh_dig_q;
    sh_dp_d  = sh_dp_q;
    an_d     = '1;
    seg_d    = 7'h7F;
    dp_n_d   = 1'b1;
    frame_d  = 1'b0;
    if (ssd_en) begin
      if (cnt_q == CW'(REFRESH_DIV - 1)) begin
        cnt_d  = '0;
        slot_d = (slot_q == SW'(NUM_DIGITS - 1)) ? '0 : slot_q + 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      if ((cnt_q == '0) && (slot_q == '0)) begin
        sh_dig_d = ssd_digits;
        sh_dp_d  = ssd_dp;
        frame_d  = 1'b1;
      end
      if (cnt_q >= CW'(BLANK_CYCLES)) begin
        an_d   = ~(NUM_DIGITS'(1) << slot_q);
        seg_d  = (ssd_lzb && cur_lz) ? 7'h7F : decode(cur_dig);
        dp_n_d = ~cur_dp;
      end
    end
  end

  always_ff @(posedge ssd_clk or negedge ssd_rst_n) begin
    if (!ssd_rst_n) begin
      cnt_q    <= '0;
      slot_q   <= '0;
      sh_dig_q <= '0;
      sh_dp_q  <= '0;
      an_q     <= '1;
      seg_q    <= 7'h7F;
      dp_n_q   <= 1'b1;
      frame_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      slot_q   <= slot_d;
      sh_dig_q <= sh_dig_d;
      sh_dp_q  <= sh_dp_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_n_q   <= dp_n_d;
      frame_q  <= frame_d;
    end
  end

  assign ssd_an    = an_q;
  assign ssd_seg   = seg_q;
  assign ssd_dp_n  = dp_n_q;
  assign ssd_frame = frame_q;

endmodule
